// File: rtl/binary_to_bcd_converter_if.sv
// ---------------------------------------------------------------------------
// binary_to_bcd_converter_if
// Groups the request/result signals of the binary-to-BCD converter.
//   start       master->slave  request a conversion of binary_in
//   binary_in   master->slave  unsigned operand (BIN_WIDTH bits)
//   busy        slave->master  conversion in progress
//   done        slave->master  one-cycle pulse, bcd_digits/overflow just updated
//   bcd_digits  slave->master  packed BCD, most significant digit in the top nibble
//   overflow    slave->master  last accepted operand exceeded 10**DIGITS-1
// The master modport is the requester (testbench or upstream logic).
// The slave modport is the converter.
// ---------------------------------------------------------------------------
interface binary_to_bcd_converter_if #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
);
  logic                  start;
  logic [BIN_WIDTH-1:0]  binary_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_digits;
  logic                  overflow;

  modport master (
    output start, binary_in,
    input  busy, done, bcd_digits, overflow
  );

  modport slave (
    input  start, binary_in,
    output busy, done, bcd_digits, overflow
  );
endinterface

// File: rtl/binary_to_bcd_converter.sv
// ---------------------------------------------------------------------------
// binary_to_bcd_converter
// Sequential double-dabble converter: one add-3/shift iteration per clock.
// Operands above 10**DIGITS-1 are saturated to that value and flagged.
// Ports:
//   clk_100_Mhz  system clock, all state on the rising edge
//   reset        asynchronous active-low reset, released synchronously upstream
//   bus          binary_to_bcd_converter_if.slave (start, binary_in, busy,
//                done, bcd_digits, overflow)
// Timing: start sampled at edge N -> 14 shift edges -> FINISH edge N+15
// registers the result and raises done for the following cycle.
// ---------------------------------------------------------------------------
module binary_to_bcd_converter #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                           clk_100_Mhz,
  input  logic                           reset,
  binary_to_bcd_converter_if.slave       bus
);

  localparam int BCD_W     = 4 * DIGITS;
  localparam int MAX_VALUE = (10 ** DIGITS) - 1;
  localparam int CNT_W     = $clog2(BIN_WIDTH + 1);

  localparam logic [BIN_WIDTH-1:0] MAX_OPERAND = BIN_WIDTH'(MAX_VALUE);
  localparam logic [CNT_W-1:0]     LAST_ITER   = CNT_W'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FINISH
  } state_t;

  state_t               state_q;
  logic [BIN_WIDTH-1:0] operand_q;
  logic [BCD_W-1:0]     acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_flag_q;
  logic                 busy_q;
  logic                 done_q;
  logic [BCD_W-1:0]     bcd_q;
  logic                 ovf_q;

  logic [BCD_W-1:0]     adj_d;
  logic [BCD_W-1:0]     acc_d;
  logic [BIN_WIDTH-1:0] operand_d;
  logic                 sat_d;

  // Add-3 correction applied to every digit before the shift, so that a
  // digit of 5..9 carries correctly into the next digit after doubling.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj_d[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ?
                                (acc_q[4*gi +: 4] + 4'd3) : acc_q[4*gi +: 4];
    end
  endgenerate

  // {acc, operand} shifted left by one as a single wide register.
  assign acc_d     = {adj_d[BCD_W-2:0], operand_q[BIN_WIDTH-1]};
  assign operand_d = {operand_q[BIN_WIDTH-2:0], 1'b0};

  assign sat_d = (bus.binary_in > MAX_OPERAND);

  always_ff @(posedge clk_100_Mhz or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      operand_q  <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            operand_q  <= sat_d ? MAX_OPERAND : bus.binary_in;
            ovf_flag_q <= sat_d;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc_q     <= acc_d;
          operand_q <= operand_d;
          if (cnt_q == LAST_ITER) begin
            state_q <= S_FINISH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FINISH: begin
          // Outputs change only here, so the display never sees partial sums.
          bcd_q   <= acc_q;
          ovf_q   <= ovf_flag_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.bcd_digits = bcd_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
module tb_binary_to_bcd_converter;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  binary_to_bcd_converter_if #(.BIN_WIDTH(14), .DIGITS(4)) bus ();

  binary_to_bcd_converter #(.BIN_WIDTH(14), .DIGITS(4)) dut (
    .clk_100_Mhz (clk),
    .reset       (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Single conversion with a one-cycle start pulse; checks busy, latency,
  // result and that done lasts only one cycle.
  task automatic convert(input logic [13:0] val, input logic [15:0] exp_bcd,
                         input logic exp_ovf, input string name);
    int  i;
    bit  seen;
    @(negedge clk);
    bus.binary_in = val;
    bus.start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk({name, " busy"}, 32'(bus.busy), 32'(1));
    i = 0;
    seen = 0;
    while (!seen && i < 40) begin
      if (bus.done) seen = 1;
      else begin
        @(negedge clk);
        i++;
      end
    end
    chk({name, " latency"}, 32'(i), 32'(15));
    chk({name, " bcd"}, 32'(bus.bcd_digits), 32'(exp_bcd));
    chk({name, " ovf"}, 32'(bus.overflow), 32'(exp_ovf));
    $display("convert %0d -> bcd=%h ovf=%b latency=%0d", val, bus.bcd_digits, bus.overflow, i);
    @(negedge clk);
    chk({name, " done pulse"}, 32'(bus.done), 32'(0));
  endtask

  initial begin
    int i;
    int dones;
    int first_done;
    int second_done;
    logic [15:0] first_bcd;
    logic [15:0] second_bcd;

    vecs[0]  = '{14'd1234,  16'h1234, 1'b0};
    vecs[1]  = '{14'd0,     16'h0000, 1'b0};
    vecs[2]  = '{14'd9999,  16'h9999, 1'b0};
    vecs[3]  = '{14'd10,    16'h0010, 1'b0};
    vecs[4]  = '{14'd12000, 16'h9999, 1'b1};
    vecs[5]  = '{14'd7,     16'h0007, 1'b0};
    vecs[6]  = '{14'd10000, 16'h9999, 1'b1};
    vecs[7]  = '{14'd16383, 16'h9999, 1'b1};
    vecs[8]  = '{14'd9998,  16'h9998, 1'b0};
    vecs[9]  = '{14'd5,     16'h0005, 1'b0};
    vecs[10] = '{14'd500,   16'h0500, 1'b0};
    vecs[11] = '{14'd8765,  16'h8765, 1'b0};

    // Reset state
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.binary_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'(0));
    chk("reset done", 32'(bus.done), 32'(0));
    chk("reset bcd", 32'(bus.bcd_digits), 32'(16'h0000));
    chk("reset ovf", 32'(bus.overflow), 32'(0));
    $display("reset: busy=%b done=%b bcd=%h ovf=%b", bus.busy, bus.done, bus.bcd_digits, bus.overflow);

    // Directed vector table
    for (int v = 0; v < 12; v++) begin
      convert(vecs[v].bin, vecs[v].bcd, vecs[v].ovf, $sformatf("vec%0d", v));
    end

    // Start pulses while busy must be ignored
    @(negedge clk);
    bus.binary_in = 14'd4321;
    bus.start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    first_done = -1;
    first_bcd = '0;
    for (i = 0; i < 45; i++) begin
      if (i == 3 || i == 8) begin
        bus.binary_in = 14'd55;
        bus.start     = 1'b1;
      end
      if (i == 5 || i == 9) bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        if (first_done < 0) begin
          first_done = i;
          first_bcd  = bus.bcd_digits;
        end
      end
      @(negedge clk);
    end
    chk("busy-start done count", 32'(dones), 32'(1));
    chk("busy-start latency", 32'(first_done), 32'(15));
    chk("busy-start bcd", 32'(first_bcd), 32'(16'h4321));
    $display("busy-start: dones=%0d bcd=%h", dones, first_bcd);

    // Back-to-back with start held high: second accepted on first IDLE cycle
    @(negedge clk);
    bus.binary_in = 14'd1111;
    bus.start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.binary_in = 14'd2222;
    dones = 0;
    first_done = -1;
    second_done = -1;
    first_bcd = '0;
    second_bcd = '0;
    for (i = 0; i < 45; i++) begin
      if (i == 16) bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        if (first_done < 0) begin
          first_done = i;
          first_bcd  = bus.bcd_digits;
        end else if (second_done < 0) begin
          second_done = i;
          second_bcd  = bus.bcd_digits;
        end
      end
      @(negedge clk);
    end
    chk("b2b done count", 32'(dones), 32'(2));
    chk("b2b first latency", 32'(first_done), 32'(15));
    chk("b2b first bcd", 32'(first_bcd), 32'(16'h1111));
    chk("b2b second latency", 32'(second_done), 32'(31));
    chk("b2b second bcd", 32'(second_bcd), 32'(16'h2222));
    $display("back-to-back: dones=%0d at %0d/%0d bcd=%h/%h", dones, first_done, second_done, first_bcd, second_bcd);

    // Reset mid-conversion aborts immediately, no done
    @(negedge clk);
    bus.binary_in = 14'd8888;
    bus.start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(bus.busy), 32'(0));
    chk("abort done", 32'(bus.done), 32'(0));
    chk("abort bcd", 32'(bus.bcd_digits), 32'(16'h0000));
    chk("abort ovf", 32'(bus.overflow), 32'(0));
    $display("abort: busy=%b done=%b bcd=%h ovf=%b", bus.busy, bus.done, bus.bcd_digits, bus.overflow);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    chk("abort no activity", 32'(dones), 32'(0));
    convert(14'd42, 16'h0042, 1'b0, "post-abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
